cpu_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32I core datapath: fetch, decode, execute, memory, writeback.

---
 rtl/cpu_seq_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB strobes, instruction register,
// bus-timeout watchdog and retired-instruction counter.
module cpu_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      imem_rdata_i,
  input  logic             imem_ack_i,
  output logic             imem_req_o,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             br_taken_i,
  output logic [31:0]      ir_o,
  output logic [2:0]       imm_sel_o,
  output logic             alu_src_b_o,
  output logic [1:0]       wb_sel_o,
  output logic             rf_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_sel_o,
  output logic             halt_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int unsigned WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic        WD_EN = (TIMEOUT_CYC != 0);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_DMEM = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [WD_W-1:0]  wait_q, wait_d;
  logic             halt_q, halt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [6:0] opcode;
  logic is_load, is_store, is_opimm, is_op, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc, is_system, is_legal;
  logic wd_hit;

  assign opcode    = ir_q[6:0];
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_system = (opcode == OPC_SYSTEM);
  assign is_legal  = is_load | is_store | is_opimm | is_op | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  // An ACK arriving in the same cycle as expiry is checked first, so it wins.
  assign wd_hit = WD_EN && (wait_q == WD_W'(TIMEOUT_CYC));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_RST;
      ir_q      <= '0;
      wait_q    <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    wait_d     = '0;
    halt_d     = halt_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    retired_d  = retired_q;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = PC_PLUS4;
    wb_sel_o   = WB_ALU;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_d    = imem_rdata_i;
          state_d = S_DECODE;
        end else if (wd_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
          halt_d    = 1'b1;
        end else if (WD_EN) begin
          wait_d = wait_q + WD_W'(1);
        end
      end

      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          halt_d    = 1'b1;
          illegal_d = !is_system;
        end
      end

      S_EXEC: state_d = (is_load || is_store) ? S_MEM : S_WB;

      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store;
        if (dmem_ack_i) begin
          // Stores retire here; there is nothing to write back.
          if (is_store) begin
            pc_we_o   = 1'b1;
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wd_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
          halt_d    = 1'b1;
        end else if (WD_EN) begin
          wait_d = wait_q + WD_W'(1);
        end
      end

      S_WB: begin
        pc_we_o   = 1'b1;
        rf_we_o   = !is_branch;
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
        if (is_jalr) begin
          pc_sel_o = PC_JALR;
        end else if (is_jal || (is_branch && br_taken_i)) begin
          pc_sel_o = PC_TARGET;
        end
        if (is_jal || is_jalr) begin
          wb_sel_o = WB_PC4;
        end else if (is_load) begin
          wb_sel_o = WB_DMEM;
        end
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    imm_sel_o   = IMM_I;
    alu_src_b_o = 1'b0;
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      alu_src_b_o = !(is_op || is_branch);
      if (is_store) begin
        imm_sel_o = IMM_S;
      end else if (is_branch) begin
        imm_sel_o = IMM_B;
      end else if (is_lui || is_auipc) begin
        imm_sel_o = IMM_U;
      end else if (is_jal) begin
        imm_sel_o = IMM_J;
      end
    end
  end

  assign ir_o      = ir_q;
  assign halt_o    = halt_q;
  assign illegal_o = illegal_q;
  assign bus_err_o = bus_err_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: phase-level reference model with randomized waits and operands.
module tb_cpu_seq_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000a103;
  localparam logic [31:0] I_SW   = 32'h0020a023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;

  typedef enum {P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_TRAP} phase_e;
  typedef struct {phase_e ph; logic ack;} step_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          imem_ack = 1'b0;
  logic          dmem_ack = 1'b0;
  logic          br_taken = 1'b0;
  logic          imem_req_o, dmem_req_o, dmem_we_o, alu_src_b_o, rf_we_o, pc_we_o;
  logic          halt_o, illegal_o, bus_err_o;
  logic [31:0]   ir_o;
  logic [2:0]    imm_sel_o;
  logic [1:0]    wb_sel_o, pc_sel_o;
  logic [CW-1:0] retired_o;

  int   tests = 0;
  int   fails = 0;
  int   exp_retired = 0;
  logic exp_halt = 1'b0, exp_ill = 1'b0, exp_bus = 1'b0;

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_rdata_i(imem_rdata), .imem_ack_i(imem_ack), .imem_req_o(imem_req_o),
    .dmem_ack_i(dmem_ack), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .br_taken_i(br_taken), .ir_o(ir_o), .imm_sel_o(imm_sel_o), .alu_src_b_o(alu_src_b_o),
    .wb_sel_o(wb_sel_o), .rf_we_o(rf_we_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
    .halt_o(halt_o), .illegal_o(illegal_o), .bus_err_o(bus_err_o), .retired_o(retired_o)
  );

  function automatic logic legal_opc(input logic [6:0] o);
    return o inside {OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  // Vector layout: {imem_req, dmem_req, dmem_we, rf_we, pc_we, pc_sel[1:0], wb_sel[1:0], imm_sel[2:0], alu_src_b}
  function automatic logic [12:0] exp_vec(input phase_e ph, input logic [6:0] o, input logic ack, input logic br);
    logic [12:0] v;
    v = '0;
    if (ph inside {P_DECODE, P_EXEC, P_MEM, P_WB}) begin
      case (o)
        OP_STORE:         v[3:1] = 3'd1;
        OP_BRANCH:        v[3:1] = 3'd2;
        OP_LUI, OP_AUIPC: v[3:1] = 3'd3;
        OP_JAL:           v[3:1] = 3'd4;
        default:          v[3:1] = 3'd0;
      endcase
      v[0] = !(o == OP_OP || o == OP_BRANCH);
    end
    case (ph)
      P_FETCH: v[12] = 1'b1;
      P_MEM: begin
        v[11] = 1'b1;
        v[10] = (o == OP_STORE);
        v[8]  = ack && (o == OP_STORE);
      end
      P_WB: begin
        v[8] = 1'b1;
        v[9] = (o != OP_BRANCH);
        if (o == OP_JALR) v[7:6] = 2'd2;
        else if (o == OP_JAL || (o == OP_BRANCH && br)) v[7:6] = 2'd1;
        if (o == OP_JAL || o == OP_JALR) v[5:4] = 2'd2;
        else if (o == OP_LOAD) v[5:4] = 2'd1;
      end
      default: ;
    endcase
    return v;
  endfunction

  // Only fields with a defined meaning in the given phase are compared.
  function automatic logic [12:0] exp_mask(input phase_e ph, input logic [6:0] o, input logic [12:0] v);
    logic [12:0] m;
    m = 13'h1B00;
    if (ph == P_MEM) m[10] = 1'b1;
    if (v[8]) m[7:6] = 2'b11;
    if (ph == P_WB && v[9]) m[5:4] = 2'b11;
    if ((ph inside {P_DECODE, P_EXEC, P_MEM, P_WB}) && legal_opc(o)) begin
      if (o != OP_OP) m[3:1] = 3'b111;
      if (o inside {OP_OP, OP_OPIMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR}) m[0] = 1'b1;
    end
    return m;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_retired = 0;
    exp_halt = 1'b0;
    exp_ill = 1'b0;
    exp_bus = 1'b0;
  endtask

  // Runs one instruction from FETCH; starts and ends on a falling edge. cyc = cycles before TRAP/next FETCH.
  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw, input logic br, output int cyc);
    step_t       q[$];
    logic [6:0]  o;
    logic [12:0] ev, m, got;
    logic [31:0] r;
    o = instr[6:0];
    cyc = 0;
    tests++;
    if (retired_o !== CW'(exp_retired)) begin
      fails++;
      $display("FAIL retired_pre instr=%08h: got %0d want %0d", instr, retired_o, exp_retired % (1 << CW));
    end
    for (int i = 0; i <= fw; i++) q.push_back('{P_FETCH, (i == fw)});
    q.push_back('{P_DECODE, 1'b0});
    if (!legal_opc(o)) begin
      repeat (3) q.push_back('{P_TRAP, 1'b0});
    end else begin
      q.push_back('{P_EXEC, 1'b0});
      if (o == OP_LOAD || o == OP_STORE)
        for (int i = 0; i <= mw; i++) q.push_back('{P_MEM, (i == mw)});
      if (o != OP_STORE) q.push_back('{P_WB, 1'b0});
    end
    foreach (q[k]) begin
      r = $urandom;
      imem_ack   = (q[k].ph == P_FETCH) ? q[k].ack : 1'($urandom_range(0, 1));
      imem_rdata = (q[k].ph == P_FETCH && q[k].ack) ? instr : r;
      dmem_ack   = (q[k].ph == P_MEM) ? q[k].ack : 1'($urandom_range(0, 1));
      br_taken   = (q[k].ph == P_WB) ? br : 1'($urandom_range(0, 1));
      #1;
      ev  = exp_vec(q[k].ph, o, q[k].ack, br);
      m   = exp_mask(q[k].ph, o, ev);
      got = {imem_req_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o, pc_sel_o, wb_sel_o, imm_sel_o, alu_src_b_o};
      tests++;
      if ((got & m) !== (ev & m)) begin
        fails++;
        $display("FAIL ctrl_%s instr=%08h step=%0d: got %013b want %013b mask %013b",
                 q[k].ph.name(), instr, k, got, ev, m);
      end
      if (q[k].ph != P_FETCH) begin
        tests++;
        if (ir_o !== instr) begin
          fails++;
          $display("FAIL ir_%s step=%0d: got %08h want %08h", q[k].ph.name(), k, ir_o, instr);
        end
      end
      if (q[k].ph == P_WB || (q[k].ph == P_MEM && q[k].ack && o == OP_STORE)) exp_retired++;
      if (q[k].ph == P_DECODE && !legal_opc(o)) begin
        exp_halt = 1'b1;
        exp_ill  = (o != OP_SYSTEM);
      end
      if (q[k].ph != P_TRAP) cyc++;
      @(negedge clk);
    end
    tests++;
    if ({halt_o, illegal_o, bus_err_o} !== {exp_halt, exp_ill, exp_bus}) begin
      fails++;
      $display("FAIL flags instr=%08h: got halt/ill/bus=%b%b%b want %b%b%b",
               instr, halt_o, illegal_o, bus_err_o, exp_halt, exp_ill, exp_bus);
    end
    tests++;
    if (retired_o !== CW'(exp_retired)) begin
      fails++;
      $display("FAIL retired_post instr=%08h: got %0d want %0d", instr, retired_o, exp_retired % (1 << CW));
    end
  endtask

  task automatic chk_latency(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL latency_%s: got %0d cycles want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    logic [12:0] got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    got = {imem_req_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o, pc_sel_o, wb_sel_o, imm_sel_o, alu_src_b_o};
    tests++;
    if (got !== '0 || ir_o !== '0 || retired_o !== '0 || {halt_o, illegal_o, bus_err_o} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: got vec=%013b ir=%08h ret=%0d flags=%b%b%b want all 0",
               got, ir_o, retired_o, halt_o, illegal_o, bus_err_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if ({imem_req_o, dmem_req_o} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release_fetch: got imem/dmem req=%b%b want 10", imem_req_o, dmem_req_o);
    end
    @(negedge clk);
  endtask

  task automatic test_alu();
    int c;
    do_reset();
    run_instr(I_ADDI, 0, 0, 1'b0, c);
    chk_latency("addi", c, 4);
    run_instr(32'h002081b3, 0, 0, 1'b0, c);
    chk_latency("add", c, 4);
    run_instr(32'h123450b7, 0, 0, 1'b0, c);
    chk_latency("lui", c, 4);
    run_instr(32'h00001097, 0, 0, 1'b0, c);
    chk_latency("auipc", c, 4);
  endtask

  task automatic test_load_store();
    int c;
    run_instr(I_LW, 0, 3, 1'b0, c);
    chk_latency("lw_wait3", c, 8);
    run_instr(I_LW, 0, 0, 1'b0, c);
    chk_latency("lw", c, 5);
    run_instr(I_SW, 0, 0, 1'b0, c);
    chk_latency("sw", c, 4);
  endtask

  task automatic test_branch_jump();
    int c;
    run_instr(I_BEQ, 0, 0, 1'b1, c);
    chk_latency("beq_taken", c, 4);
    run_instr(I_BEQ, 0, 0, 1'b0, c);
    chk_latency("beq_not_taken", c, 4);
    run_instr(32'h008000ef, 0, 0, 1'b0, c);
    chk_latency("jal", c, 4);
    run_instr(32'h000080e7, 0, 0, 1'b1, c);
    chk_latency("jalr", c, 4);
  endtask

  task automatic test_back_to_back();
    logic [6:0]  opcs [9] = '{OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    logic [31:0] r;
    int c, fw, mw;
    for (int n = 0; n < 60; n++) begin
      r  = $urandom;
      fw = $urandom_range(0, TO);
      mw = $urandom_range(0, TO);
      run_instr({r[31:7], opcs[$urandom_range(0, 8)]}, fw, mw, 1'($urandom_range(0, 1)), c);
    end
  endtask

  task automatic test_timeout();
    int c;
    do_reset();
    for (int i = 0; i < TO + 1; i++) begin
      imem_ack = 1'b0;
      #1;
      tests++;
      if (imem_req_o !== 1'b1) begin
        fails++;
        $display("FAIL wd_fetch_req cycle=%0d: got %b want 1", i, imem_req_o);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      #1;
      tests++;
      if ({bus_err_o, halt_o, illegal_o, imem_req_o, dmem_req_o} !== 5'b11000) begin
        fails++;
        $display("FAIL wd_fetch_trap cycle=%0d: got bus/halt/ill/ireq/dreq=%b%b%b%b%b want 11000",
                 i, bus_err_o, halt_o, illegal_o, imem_req_o, dmem_req_o);
      end
      @(negedge clk);
    end
    do_reset();
    run_instr(I_ADDI, TO, 0, 1'b0, c);
    chk_latency("ack_at_limit", c, TO + 4);
    imem_ack = 1'b1;
    imem_rdata = I_LW;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < TO + 1; i++) begin
      dmem_ack = 1'b0;
      #1;
      tests++;
      if (dmem_req_o !== 1'b1) begin
        fails++;
        $display("FAIL wd_mem_req cycle=%0d: got %b want 1", i, dmem_req_o);
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if ({dmem_req_o, bus_err_o, halt_o} !== 3'b011) begin
      fails++;
      $display("FAIL wd_mem_trap: got dreq/bus/halt=%b%b%b want 011", dmem_req_o, bus_err_o, halt_o);
    end
  endtask

  task automatic test_illegal();
    int c;
    do_reset();
    run_instr(I_ADDI, 0, 0, 1'b0, c);
    run_instr(32'h0000007f, 0, 0, 1'b0, c);
    do_reset();
    tests++;
    if ({halt_o, illegal_o} !== 2'b00) begin
      fails++;
      $display("FAIL illegal_cleared: got halt/ill=%b%b want 00", halt_o, illegal_o);
    end
    run_instr(I_SW, 0, 1, 1'b0, c);
    run_instr(32'h00000073, 0, 0, 1'b0, c);
  endtask

  task automatic test_reset_mid_mem();
    int c;
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(I_ADDI, 0, 0, 1'b0, c);
    imem_ack = 1'b1;
    imem_rdata = I_LW;
    @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (dmem_req_o !== 1'b1) begin
      fails++;
      $display("FAIL mid_mem_req: got %b want 1", dmem_req_o);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if ({imem_req_o, dmem_req_o} !== 2'b00 || retired_o !== '0) begin
      fails++;
      $display("FAIL mid_mem_abort: got ireq/dreq=%b%b ret=%0d want 00 ret=0", imem_req_o, dmem_req_o, retired_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (imem_req_o !== 1'b1) begin
      fails++;
      $display("FAIL mid_mem_resume: got imem_req=%b want 1", imem_req_o);
    end
    exp_retired = 0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_alu();
    test_load_store();
    test_branch_jump();
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "time limit");
  end

endmodule
